// File: rtl/sfilt_seq.sv
// FIR sequencer for the serial filter datapath: keeps the sample delay line and
// coefficient file, issues the per-sample sfilt command stream and forwards results.
module sfilt_seq #(
  parameter int NTAPS = 8,
  parameter int SHIFT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pushin,
  input  logic [31:0] din,
  output logic        rdy,
  input  logic        coef_we,
  input  logic [3:0]  coef_addr,
  input  logic [31:0] coef_data,
  output logic        coef_err,
  output logic        f_pushin,
  output logic [1:0]  f_cmd,
  output logic [31:0] f_q,
  output logic [31:0] f_h,
  input  logic        f_pushout,
  input  logic [31:0] f_z,
  output logic        pushout,
  output logic [31:0] z,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    SHF  = 2'd2,
    OUT  = 2'd3
  } state_t;

  localparam logic [3:0] LAST = 4'(NTAPS - 1);

  state_t      state_r;
  logic [3:0]  wp_r;
  logic [3:0]  k_r;
  logic [3:0]  pend_r;
  logic [31:0] x_r    [16];
  logic [31:0] coef_r [16];

  logic        accept_s;
  logic        coef_ok_s;
  logic        pend_inc_s;
  logic        pend_dec_s;
  logic [3:0]  wp_next_s;
  logic [3:0]  k_next_s;
  logic [3:0]  rd_idx_s;
  logic [31:0] h0_s;

  // Next-command addressing; a coefficient written in the accept cycle is forwarded to tap 0.
  always_comb begin
    accept_s   = (state_r == IDLE) && pushin;
    coef_ok_s  = coef_we && (state_r == IDLE) && ({1'b0, coef_addr} < 5'(NTAPS));
    pend_inc_s = (state_r == OUT);
    pend_dec_s = f_pushout;
    k_next_s   = k_r + 4'd1;
    if (wp_r == LAST) begin
      wp_next_s = 4'd0;
    end else begin
      wp_next_s = wp_r + 4'd1;
    end
    if (wp_r >= k_next_s) begin
      rd_idx_s = wp_r - k_next_s;
    end else begin
      rd_idx_s = wp_r + 4'(NTAPS) - k_next_s;
    end
    if (coef_ok_s && (coef_addr == 4'd0)) begin
      h0_s = coef_data;
    end else begin
      h0_s = coef_r[0];
    end
  end

  assign rdy  = (state_r == IDLE);
  assign busy = (state_r != IDLE) || (pend_r != 4'd0);

  // Sequencer FSM with registered command outputs; each state's command is set on entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      wp_r     <= 4'd0;
      k_r      <= 4'd0;
      pend_r   <= 4'd0;
      coef_err <= 1'b0;
      f_pushin <= 1'b0;
      f_cmd    <= 2'd0;
      f_q      <= 32'd0;
      f_h      <= 32'd0;
      pushout  <= 1'b0;
      z        <= 32'd0;
      for (int i = 0; i < 16; i++) begin
        x_r[i]    <= 32'd0;
        coef_r[i] <= 32'd0;
      end
    end else begin
      coef_err <= coef_we && !coef_ok_s;
      if (coef_ok_s) begin
        coef_r[coef_addr] <= coef_data;
      end
      pushout <= f_pushout;
      if (f_pushout) begin
        z <= f_z;
      end
      // Saturating outstanding-result counter
      case ({pend_inc_s, pend_dec_s})
        2'b10:   if (pend_r != 4'hF) pend_r <= pend_r + 4'd1;
        2'b01:   if (pend_r != 4'h0) pend_r <= pend_r - 4'd1;
        default: pend_r <= pend_r;
      endcase
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            x_r[wp_next_s] <= din;
            wp_r     <= wp_next_s;
            k_r      <= 4'd0;
            f_pushin <= 1'b1;
            f_cmd    <= 2'd0;
            f_q      <= din;
            f_h      <= h0_s;
            state_r  <= MAC;
          end else begin
            f_pushin <= 1'b0;
            f_cmd    <= 2'd0;
            f_q      <= 32'd0;
            f_h      <= 32'd0;
          end
        end
        MAC: begin
          if (k_r == LAST) begin
            f_cmd   <= 2'd2;
            f_q     <= 32'd0;
            f_h     <= 32'(SHIFT);
            state_r <= SHF;
          end else begin
            k_r   <= k_next_s;
            f_cmd <= 2'd1;
            f_q   <= x_r[rd_idx_s];
            f_h   <= coef_r[k_next_s];
          end
        end
        SHF: begin
          f_cmd   <= 2'd3;
          f_q     <= 32'd0;
          f_h     <= 32'd0;
          state_r <= OUT;
        end
        OUT: begin
          f_pushin <= 1'b0;
          f_cmd    <= 2'd0;
          state_r  <= IDLE;
        end
        default: begin
          f_pushin <= 1'b0;
          f_cmd    <= 2'd0;
          f_q      <= 32'd0;
          f_h      <= 32'd0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sfilt_seq.sv
// Directed bench for sfilt_seq: two sequencers (SHIFT=0 and SHIFT=1, NTAPS=4)
// share stimulus, each driving a behavioural sfilt datapath.
module tb_sfilt_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pushin = 1'b0;
  logic [31:0] din = 32'd0;
  logic        coef_we = 1'b0;
  logic [3:0]  coef_addr = 4'd0;
  logic [31:0] coef_data = 32'd0;

  logic        rdy_v      [2];
  logic        coef_err_v [2];
  logic        f_pushin_v [2];
  logic [1:0]  f_cmd_v    [2];
  logic [31:0] f_h_v      [2];
  logic        pushout_v  [2];
  logic [31:0] z_v        [2];
  logic        busy_v     [2];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic        rdy_l, coef_err_l, f_pushin_l, f_pushout_l, pushout_l, busy_l;
    logic [1:0]  f_cmd_l;
    logic [31:0] f_q_l, f_h_l, f_z_l, z_l;
    longint      acc;
    longint      prod;

    sfilt_seq #(.NTAPS(4), .SHIFT(g)) u_dut (
      .clk(clk), .rst(rst), .pushin(pushin), .din(din), .rdy(rdy_l),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
      .coef_err(coef_err_l), .f_pushin(f_pushin_l), .f_cmd(f_cmd_l),
      .f_q(f_q_l), .f_h(f_h_l), .f_pushout(f_pushout_l), .f_z(f_z_l),
      .pushout(pushout_l), .z(z_l), .busy(busy_l)
    );

    assign prod = longint'($signed(f_q_l)) * longint'($signed(f_h_l));

    // Behavioural sfilt: multiply, accumulate, round-shift, emit acc one cycle after cmd3
    always_ff @(posedge clk) begin
      if (rst) begin
        acc         <= 64'sd0;
        f_pushout_l <= 1'b0;
        f_z_l       <= 32'd0;
      end else begin
        f_pushout_l <= 1'b0;
        if (f_pushin_l) begin
          case (f_cmd_l)
            2'd0: acc <= prod;
            2'd1: acc <= acc + prod;
            2'd2: acc <= (f_h_l == 32'd0) ? acc : ((acc + (64'sd1 <<< (f_h_l - 32'd1))) >>> f_h_l);
            default: begin
              f_pushout_l <= 1'b1;
              f_z_l       <= acc[31:0];
            end
          endcase
        end
      end
    end

    assign rdy_v[g]      = rdy_l;
    assign coef_err_v[g] = coef_err_l;
    assign f_pushin_v[g] = f_pushin_l;
    assign f_cmd_v[g]    = f_cmd_l;
    assign f_h_v[g]      = f_h_l;
    assign pushout_v[g]  = pushout_l;
    assign z_v[g]        = z_l;
    assign busy_v[g]     = busy_l;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wcoef(input logic [3:0] a, input logic [31:0] d, input logic exp_err);
    coef_we = 1'b1; coef_addr = a; coef_data = d;
    tick();
    coef_we = 1'b0;
    chk("coef_err", {31'd0, coef_err_v[0]}, {31'd0, exp_err});
  endtask

  task automatic coefs_1234();
    for (int i = 0; i < 4; i++) wcoef(4'(i), 32'(i + 1), 1'b0);
  endtask

  task automatic send(input logic [31:0] d);
    int n = 0;
    while (rdy_v[0] !== 1'b1 && n < 40) begin tick(); n++; end
    chk("rdy_wait", {31'd0, rdy_v[0]}, 32'd1);
    din = d; pushin = 1'b1;
    tick();
    pushin = 1'b0;
  endtask

  task automatic wait_out(input int g, input logic [31:0] exp, input string tag);
    int n = 0;
    while (pushout_v[g] !== 1'b1 && n < 40) begin tick(); n++; end
    chk({tag, "_seen"}, {31'd0, pushout_v[g]}, 32'd1);
    chk(tag, z_v[g], exp);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] s4 [6]   = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
    logic [31:0] e4 [6]   = '{32'd1, 32'd4, 32'd10, 32'd20, 32'd30, 32'd40};
    logic [1:0]  ecmd [6] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3};
    logic [31:0] e1 [5]   = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd0};
    int nacc, npo, last;

    tick(); tick();
    rst = 1'b0;
    chk("rst_rdy", {31'd0, rdy_v[0]}, 32'd1);
    chk("rst_busy", {31'd0, busy_v[0]}, 32'd0);
    chk("rst_f_pushin", {31'd0, f_pushin_v[0]}, 32'd0);
    chk("rst_f_h", f_h_v[1], 32'd0);
    chk("rst_pushout", {31'd0, pushout_v[0]}, 32'd0);
    chk("rst_z", z_v[0], 32'd0);
    chk("rst_coef_err", {31'd0, coef_err_v[0]}, 32'd0);

    // 1. impulse response with coefficients 1..4, SHIFT=0
    coefs_1234();
    for (int i = 0; i < 5; i++) begin
      send(i == 0 ? 32'd1 : 32'd0);
      wait_out(0, e1[i], "impulse");
    end
    tick();
    chk("pushout_pulse", {31'd0, pushout_v[0]}, 32'd0);

    // 2. command stream and rounding shift on the SHIFT=1 instance
    do_reset();
    for (int i = 0; i < 4; i++) wcoef(4'(i), 32'd1, 1'b0);
    send(32'd3);
    for (int i = 0; i < 6; i++) begin
      chk("cmd_f_pushin", {31'd0, f_pushin_v[1]}, 32'd1);
      chk("cmd_seq", {30'd0, f_cmd_v[1]}, {30'd0, ecmd[i]});
      if (i == 4) chk("shf_f_h", f_h_v[1], 32'd1);
      tick();
    end
    chk("cmd_idle", {31'd0, f_pushin_v[1]}, 32'd0);
    wait_out(1, 32'd2, "round_shift");

    // 3. negative coefficient
    do_reset();
    wcoef(4'd0, 32'hFFFF_FFFF, 1'b0);
    for (int i = 1; i < 4; i++) wcoef(4'(i), 32'd0, 1'b0);
    send(32'd7);
    wait_out(0, 32'hFFFF_FFF9, "neg_coef");
    send(32'd0);
    wait_out(0, 32'd0, "neg_coef_zero");

    // 4. pushin held high for six samples
    do_reset();
    coefs_1234();
    nacc = 0; npo = 0; last = 0;
    pushin = 1'b1;
    for (int c = 0; c < 150 && npo < 6; c++) begin
      if (pushout_v[0] === 1'b1) begin
        chk("stream_z", z_v[0], e4[npo]);
        npo++;
      end
      if (nacc > 0 && npo < 6) chk("stream_busy", {31'd0, busy_v[0]}, 32'd1);
      if (rdy_v[0] === 1'b1) begin
        if (nacc < 6) begin
          if (nacc > 0) chk("accept_interval", 32'(c - last), 32'd7);
          last = c;
          din = s4[nacc];
          nacc++;
        end else begin
          pushin = 1'b0;
        end
      end
      tick();
    end
    pushin = 1'b0;
    chk("stream_pushouts", 32'(npo), 32'd6);
    chk("stream_accepts", 32'(nacc), 32'd6);
    chk("stream_busy_end", {31'd0, busy_v[0]}, 32'd0);

    // 5. dropped coefficient writes, then a write taken together with a sample
    do_reset();
    coefs_1234();
    send(32'd1);
    coef_we = 1'b1; coef_addr = 4'd0; coef_data = 32'd100;
    tick();
    coef_we = 1'b0;
    chk("busy_we_err", {31'd0, coef_err_v[0]}, 32'd1);
    tick();
    chk("busy_we_pulse", {31'd0, coef_err_v[0]}, 32'd0);
    wait_out(0, 32'd1, "busy_we_z");
    wcoef(4'd4, 32'd77, 1'b1);
    send(32'd0);
    wait_out(0, 32'd2, "old_coef_z1");
    send(32'd5);
    wait_out(0, 32'd8, "old_coef_z2");
    coef_we = 1'b1; coef_addr = 4'd0; coef_data = 32'd10;
    din = 32'd2; pushin = 1'b1;
    tick();
    coef_we = 1'b0; pushin = 1'b0;
    chk("same_cycle_err", {31'd0, coef_err_v[0]}, 32'd0);
    wait_out(0, 32'd34, "same_cycle_z");

    // 6. reset in the middle of MAC
    send(32'd9);
    tick(); tick();
    chk("mid_mac_cmd", {30'd0, f_cmd_v[0]}, 32'd1);
    do_reset();
    chk("abort_f_pushin", {31'd0, f_pushin_v[0]}, 32'd0);
    chk("abort_rdy", {31'd0, rdy_v[0]}, 32'd1);
    chk("abort_busy", {31'd0, busy_v[0]}, 32'd0);
    chk("abort_wp", {28'd0, g_dut[0].u_dut.wp_r}, 32'd0);
    coefs_1234();
    for (int i = 0; i < 5; i++) begin
      send(i == 0 ? 32'd1 : 32'd0);
      wait_out(0, e1[i], "post_reset_impulse");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
